reg_file_scoreboard: RTL and testbench

- Architectural register file for the pipeline: the receiving end of the writeback interface (rd_wb, rd_address_wb, rd_data_wb).
- Serves two registered read ports (rs, rt) to decode, with same-cycle write bypass.
- Tracks a pending-write scoreboard so decode can detect RAW hazards on in-flight destinations.
- Exposes the storage as the reg_file debug array.

---
 rtl/reg_file_scoreboard_if.sv | 16 +
 rtl/reg_file_scoreboard.sv | 116 +++++++++++
 tb/tb_reg_file_scoreboard.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/reg_file_scoreboard_if.sv
// Writeback bus into the architectural register file.
//   rd_wb          : writeback write enable
//   rd_address_wb  : writeback destination register
//   rd_data_wb     : writeback data
// master drives the bus (writeback stage); slave receives it (register file).
interface reg_file_scoreboard_if #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      rd_wb;
  logic [REG_ADDR_WIDTH-1:0] rd_address_wb;
  logic [WIDTH-1:0]          rd_data_wb;

  modport master (output rd_wb, output rd_address_wb, output rd_data_wb);
  modport slave  (input  rd_wb, input  rd_address_wb, input  rd_data_wb);
endinterface

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with two registered read ports (rs, rt),
// same-cycle writeback bypass, and a pending-write scoreboard for RAW
// hazard detection in decode.
//   clk, rst          : rising-edge clock, asynchronous active-low reset
//   stall             : freeze read ports and issue (writes still commit)
//   flush             : clear scoreboard, drop current read
//   wb                : writeback bus (slave)
//   read_en           : operand read request
//   rs/rt_address     : read port addresses
//   issue_rd(_address): destination of the instruction being issued
//   rs/rt_data        : registered read data
//   rs/rt_busy        : registered pending-write flag at read time
//   read_valid        : rs/rt outputs hold a fresh read
//   reg_file          : storage view of r1..r(REG_COUNT-1), index 0 = r1
module reg_file_scoreboard #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned REG_COUNT      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  reg_file_scoreboard_if.slave      wb,
  input  logic                      read_en,
  input  logic [REG_ADDR_WIDTH-1:0] rs_address,
  input  logic [REG_ADDR_WIDTH-1:0] rt_address,
  input  logic                      issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd_address,
  output logic [WIDTH-1:0]          rs_data,
  output logic [WIDTH-1:0]          rt_data,
  output logic                      rs_busy,
  output logic                      rt_busy,
  output logic                      read_valid,
  output logic [WIDTH-1:0]          reg_file [0:REG_COUNT-2]
);

  // r0 has no storage; index 0 of busy is tied low.
  logic [WIDTH-1:0]     mem [1:REG_COUNT-1];
  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] busy_next;

  logic             wb_write;
  logic             rs_hit, rt_hit;
  logic [WIDTH-1:0] rs_next, rt_next;
  logic             rs_busy_next, rt_busy_next;

  assign wb_write = wb.rd_wb && (wb.rd_address_wb != '0);

  always_comb begin
    for (int unsigned i = 0; i < REG_COUNT - 1; i++) begin
      reg_file[i] = mem[i + 1];
    end
  end

  // A read that coincides with a writeback to the same register takes the
  // writeback data and reports not-busy, since that data is now current.
  always_comb begin
    rs_hit  = wb_write && (wb.rd_address_wb == rs_address);
    rt_hit  = wb_write && (wb.rd_address_wb == rt_address);
    rs_next = '0;
    rt_next = '0;
    if (rs_address != '0) rs_next = rs_hit ? wb.rd_data_wb : mem[rs_address];
    if (rt_address != '0) rt_next = rt_hit ? wb.rd_data_wb : mem[rt_address];
    rs_busy_next = busy[rs_address] && !rs_hit;
    rt_busy_next = busy[rt_address] && !rt_hit;
  end

  // Clear before set: an issue in the same cycle as a writeback to the same
  // register belongs to a newer instruction, so the bit must stay set.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wb_write) busy_next[wb.rd_address_wb] = 1'b0;
      if (issue_rd && !stall && (issue_rd_address != '0))
        busy_next[issue_rd_address] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 1; i < REG_COUNT; i++) mem[i] <= '0;
    end else if (wb_write) begin
      mem[wb.rd_address_wb] <= wb.rd_data_wb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_data    <= '0;
      rt_data    <= '0;
      rs_busy    <= 1'b0;
      rt_busy    <= 1'b0;
      read_valid <= 1'b0;
    end else if (flush) begin
      read_valid <= 1'b0;
    end else if (!stall) begin
      read_valid <= read_en;
      if (read_en) begin
        rs_data <= rs_next;
        rt_data <= rt_next;
        rs_busy <= rs_busy_next;
        rt_busy <= rt_busy_next;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, read_en, issue_rd;
  logic [4:0]  rs_address, rt_address, issue_rd_address;
  logic [31:0] rs_data, rt_data;
  logic        rs_busy, rt_busy, read_valid;
  logic [31:0] reg_file [0:30];

  int unsigned tests = 0;
  int unsigned fails = 0;

  reg_file_scoreboard_if #(.WIDTH(32), .REG_ADDR_WIDTH(5)) wb ();

  reg_file_scoreboard #(.WIDTH(32), .REG_ADDR_WIDTH(5), .REG_COUNT(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .flush            (flush),
    .wb               (wb),
    .read_en          (read_en),
    .rs_address       (rs_address),
    .rt_address       (rt_address),
    .issue_rd         (issue_rd),
    .issue_rd_address (issue_rd_address),
    .rs_data          (rs_data),
    .rt_data          (rt_data),
    .rs_busy          (rs_busy),
    .rt_busy          (rt_busy),
    .read_valid       (read_valid),
    .reg_file         (reg_file)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; read_en = 0; issue_rd = 0;
    wb.rd_wb = 0;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    wb.rd_wb = 1; wb.rd_address_wb = a; wb.rd_data_wb = d;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    read_en = 1; rs_address = a; rt_address = b;
  endtask

  logic [31:0] orall;

  initial begin
    rst = 0;
    idle();
    rs_address = 0; rt_address = 0; issue_rd_address = 0;
    wb.rd_address_wb = 0; wb.rd_data_wb = 0;
    tick(); tick();
    check("rst_rs_data", rs_data, 0);
    check("rst_valid", {31'b0, read_valid}, 0);
    check("rst_rs_busy", {31'b0, rs_busy}, 0);
    rst = 1;
    tick();

    // write then read
    write(5, 32'hDEADBEEF); tick(); idle();
    check("wr_regfile4", reg_file[4], 32'hDEADBEEF);
    rd(5, 0); tick(); idle();
    check("rd_rs5", rs_data, 32'hDEADBEEF);
    check("rd_rt0", rt_data, 0);
    check("rd_valid", {31'b0, read_valid}, 1);
    check("rd_busy5", {31'b0, rs_busy}, 0);
    tick();
    check("noread_valid", {31'b0, read_valid}, 0);
    check("noread_hold", rs_data, 32'hDEADBEEF);

    // bypass
    write(7, 32'h12345678); rd(7, 5); tick(); idle();
    check("byp_rs7", rs_data, 32'h12345678);
    check("byp_rt5", rt_data, 32'hDEADBEEF);
    write(0, 32'hFFFFFFFF); rd(0, 0); tick(); idle();
    check("r0_byp_rs", rs_data, 0);
    check("r0_byp_rt", rt_data, 0);
    rd(0, 7); tick(); idle();
    check("r0_read", rs_data, 0);
    check("r7_read", rt_data, 32'h12345678);
    check("r0_regfile0", reg_file[0], 0);

    // scoreboard
    issue_rd = 1; issue_rd_address = 9; tick(); idle();
    rd(9, 9); tick(); idle();
    check("sb_rs_busy9", {31'b0, rs_busy}, 1);
    check("sb_rt_busy9", {31'b0, rt_busy}, 1);
    rd(9, 0); write(9, 32'h55); tick(); idle();
    check("sb_wb_busy", {31'b0, rs_busy}, 0);
    check("sb_wb_data", rs_data, 32'h55);
    issue_rd = 1; issue_rd_address = 9; write(9, 32'h66); tick(); idle();
    rd(9, 0); tick(); idle();
    check("sb_setwins", {31'b0, rs_busy}, 1);
    check("sb_setwins_d", rs_data, 32'h66);
    write(9, 32'h77); tick(); idle();
    rd(9, 0); tick(); idle();
    check("sb_cleared", {31'b0, rs_busy}, 0);
    check("sb_cleared_d", rs_data, 32'h77);
    issue_rd = 1; issue_rd_address = 10; rd(10, 0); tick(); idle();
    check("sb_preissue", {31'b0, rs_busy}, 0);
    rd(0, 10); tick(); idle();
    check("sb_postissue", {31'b0, rt_busy}, 1);
    issue_rd = 1; issue_rd_address = 0; tick(); idle();
    rd(0, 0); tick(); idle();
    check("sb_r0_busy", {31'b0, rs_busy}, 0);
    write(10, 32'h0); tick(); idle();

    // stall
    rd(5, 0); tick();
    check("st_pre_valid", {31'b0, read_valid}, 1);
    stall = 1; rd(7, 7); write(5, 32'h1); issue_rd = 1; issue_rd_address = 11;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("st_hold_data", rs_data, 32'hDEADBEEF);
      check("st_hold_valid", {31'b0, read_valid}, 1);
    end
    idle();
    check("st_storage", reg_file[4], 32'h1);
    rd(11, 5); tick(); idle();
    check("st_no_issue", {31'b0, rs_busy}, 0);
    check("st_rt5", rt_data, 32'h1);

    // flush (dominates stall, ignores issue)
    issue_rd = 1; issue_rd_address = 3; tick();
    issue_rd_address = 4; tick(); idle();
    rd(3, 4); tick(); idle();
    check("fl_pre_busy3", {31'b0, rs_busy}, 1);
    check("fl_pre_busy4", {31'b0, rt_busy}, 1);
    flush = 1; stall = 1; rd(3, 4); issue_rd = 1; issue_rd_address = 12; tick(); idle();
    check("fl_valid", {31'b0, read_valid}, 0);
    rd(3, 12); tick(); idle();
    check("fl_busy3", {31'b0, rs_busy}, 0);
    check("fl_busy12", {31'b0, rt_busy}, 0);
    check("fl_valid_after", {31'b0, read_valid}, 1);

    // async reset mid-stream
    write(2, 32'hAB); issue_rd = 1; issue_rd_address = 6; tick(); idle();
    rd(2, 0); tick(); idle();
    check("ar_pre_data", rs_data, 32'hAB);
    #3 rst = 0;
    #1;
    check("ar_rs_data", rs_data, 0);
    check("ar_valid", {31'b0, read_valid}, 0);
    orall = 0;
    for (int i = 0; i < 31; i++) orall |= reg_file[i];
    check("ar_regfile", orall, 0);
    #2 rst = 1;
    tick();
    rd(6, 2); tick(); idle();
    check("ar_busy6", {31'b0, rs_busy}, 0);
    check("ar_rt2", rt_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
